// File: rtl/ntt_pkg.sv
// Shared types for the NTT datapath: coefficient type, pointwise-multiplier FSM states
// and the bit-length helper used to derive the Barrett shift from q.
package ntt_pkg;

  localparam int N_LOG_DEF = 12;
  localparam int N_DEF     = 4096;

  typedef logic [63:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pwm_state_t;

  // Position of the highest set bit plus one (0 for v == 0).
  function automatic logic [6:0] bit_len(input coeff_t v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = 7'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/mod_mult.sv
// Combinational Barrett core: r = a*b mod q with k = bit_len(q), mu = floor(2^(2k) / q)
// and shift = 2k. For a, b < q the quotient estimate is low by at most one.
module mod_mult
  import ntt_pkg::*;
(
  input  coeff_t     a_i,
  input  coeff_t     b_i,
  input  coeff_t     q_i,
  input  coeff_t     mu_i,
  input  logic [7:0] shift_i,
  output coeff_t     r_o
);

  logic [127:0] prod;
  logic [191:0] est;
  coeff_t       rem;

  assign prod = {64'b0, a_i} * {64'b0, b_i};
  assign est  = ({64'b0, prod} * {128'b0, mu_i}) >> shift_i;

  // The estimated quotient never overshoots, so the remainder is in [0, 2q).
  assign rem = 64'(prod - 128'(est * {128'b0, q_i}));
  assign r_o = (rem >= q_i) ? (rem - q_i) : rem;

endmodule

// File: rtl/pointwise_mod_mul.sv
// Coefficient-wise a*b mod q over one N-point polynomial per start, PIPE-stage pipe that
// freezes whole on output stall. PWM_ACC_EN adds the c stream: result = (a*b + c) mod q.
module pointwise_mod_mul
  import ntt_pkg::*;
#(
  parameter int N_LOG = N_LOG_DEF,
  parameter int N     = N_DEF,
  parameter int PIPE  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] q,
  input  logic [63:0] mu,
  input  logic        a_valid,
  input  logic [63:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [63:0] b_data,
  output logic        b_ready,
`ifdef PWM_ACC_EN
  input  logic        c_valid,
  input  logic [63:0] c_data,
  output logic        c_ready,
`endif
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic        o_last,
  input  logic        o_ready,
  output logic        busy,
  output logic        done
);

  localparam int CW = N_LOG + 1;

  pwm_state_t    state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  coeff_t        q_lat_q, mu_lat_q;
  logic [7:0]    shift_q;
  logic [PIPE-1:0] vld_q;
  coeff_t        dat_q [PIPE];

  logic   adv, ok, in_hs, out_hs;
  coeff_t res_mul, res;

  assign o_valid = vld_q[PIPE-1];
  assign o_data  = dat_q[PIPE-1];
  assign adv     = !o_valid || o_ready;
  assign ok      = (state_q == RUN) && (in_cnt_q < CW'(N)) && adv;

`ifdef PWM_ACC_EN
  assign in_hs   = ok && a_valid && b_valid && c_valid;
  assign c_ready = in_hs;
`else
  assign in_hs   = ok && a_valid && b_valid;
`endif
  assign a_ready = in_hs;
  assign b_ready = in_hs;

  assign out_hs = o_valid && o_ready;
  assign o_last = o_valid && (out_cnt_q == CW'(N - 1));
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

  mod_mult u_mod_mult (
    .a_i     (a_data),
    .b_i     (b_data),
    .q_i     (q_lat_q),
    .mu_i    (mu_lat_q),
    .shift_i (shift_q),
    .r_o     (res_mul)
  );

`ifdef PWM_ACC_EN
  logic [64:0] acc_sum;
  assign acc_sum = {1'b0, res_mul} + {1'b0, c_data};
  assign res = (acc_sum >= {1'b0, q_lat_q}) ? 64'(acc_sum - {1'b0, q_lat_q}) : acc_sum[63:0];
`else
  assign res = res_mul;
`endif

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      RUN: begin
        if (in_hs)  in_cnt_d  = in_cnt_q + CW'(1);
        if (out_hs) out_cnt_d = out_cnt_q + CW'(1);
        if (out_hs && o_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Modulus and Barrett constants are frozen for the whole polynomial.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_lat_q  <= '0;
      mu_lat_q <= '0;
      shift_q  <= '0;
    end else if (state_q == IDLE && start) begin
      q_lat_q  <= q;
      mu_lat_q <= mu;
      shift_q  <= {bit_len(q), 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE; i++) dat_q[i] <= '0;
    end else if (adv) begin
      vld_q[0] <= in_hs;
      if (in_hs) dat_q[0] <= res;
      for (int i = 1; i < PIPE; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

endmodule
